// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the round-robin arbiters: FSM state encoding,
// requester count and the index/vector types derived from it.
package rr_arbiter_8_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = $clog2(NUM_REQ);

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    typedef logic [IDX_W-1:0]   req_idx_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;

endpackage

// File: rtl/rr_arbiter_8_decoder.sv
// 3-to-8 one-hot decoder; every resource select in the datapath uses this
// encoding so grant vectors and mux selects always agree.
module decoder_3to8
    import rr_arbiter_8_pkg::*;
(
    input  logic [2:0] idx,
    output logic [7:0] onehot
);

    // Drive exactly one bit high for the given index.
    always_comb begin
        // NOTE: assign a default before the selective write so no latch is inferred.
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter. One owner at a time; the grant is held until
// the owner signals done, drops its request, or MAX_HOLD cycles elapse. After
// every release the search pointer moves past the last owner.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 16   // 0 disables the forced revoke
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    arb_state_e        state;
    arb_state_e        state_next;
    req_idx_t          ptr;
    req_idx_t          pick_idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic              owner_release;
    logic              hold_expired;
    logic              grant_exit;
    req_vec_t          idx_onehot;

    // First set request scanning ptr, ptr+1, ... ptr+7 (mod 8).
    function automatic req_idx_t rr_pick(input req_vec_t r, input req_idx_t p);
        req_idx_t cand;
        req_idx_t sel;
        logic     found;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = p + req_idx_t'(i);
            if (!found && r[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick_idx      = rr_pick(req, ptr);
    // A normal release (done or owner gone) takes precedence over the timeout.
    assign owner_release = done | ~req[gnt_idx];
    assign hold_expired  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign grant_exit    = (state == ARB_GRANT) && (owner_release || hold_expired);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: grant on any request, leave GRANT on the first exit event.
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:  if (req != '0) state_next = ARB_GRANT;
            ARB_GRANT: if (grant_exit) state_next = ARB_IDLE;
            default:   state_next = ARB_IDLE;
        endcase
    end

    // Owner index, priority pointer, hold counter and timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_idx  <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == ARB_IDLE) begin
                if (req != '0) begin
                    gnt_idx  <= pick_idx;
                    hold_cnt <= '0;
                end
            end else if (grant_exit) begin
                ptr     <= gnt_idx + 3'd1;
                timeout <= hold_expired & ~owner_release;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    decoder_3to8 u_decoder (
        .idx    (gnt_idx),
        .onehot (idx_onehot)
    );

    // Outputs decoded from registers only.
    always_comb begin
        gnt_valid = (state == ARB_GRANT);
        gnt       = idx_onehot & {NUM_REQ{gnt_valid}};
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios plus random
// stimulus, every cycle compared against a behavioural round-robin model.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    always #5 clk = ~clk;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the resource, for how many cycles so far,
    // and where the next search starts.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_to;

    bit prev_valid = 1'b0;
    int order[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_edge(input logic [7:0] r, input logic d);
        int  c;
        bit  rel;
        bit  expired;
        m_to = 1'b0;
        if (!m_busy) begin
            for (int i = 0; i < 8; i++) begin
                c = (m_ptr + i) % 8;
                if (!m_busy && r[c]) begin
                    m_owner = c;
                    m_busy  = 1'b1;
                    m_held  = 1;
                end
            end
        end else begin
            rel     = d || !r[m_owner];
            expired = (MAX_HOLD != 0) && (m_held >= MAX_HOLD);
            if (rel || expired) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % 8;
                m_to   = expired && !rel;
            end else begin
                m_held++;
            end
        end
    endfunction

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge(req, done);
        else       model_reset();
        @(negedge clk);
        check("gnt",       gnt,       m_busy ? (32'd1 << m_owner) : 32'd0);
        check("gnt_idx",   gnt_idx,   m_owner);
        check("gnt_valid", gnt_valid, m_busy);
        check("timeout",   timeout,   m_to);
        if (gnt_valid && !prev_valid) order.push_back(int'(gnt_idx));
        prev_valid = gnt_valid;
    endtask

    task automatic drain();
        req  = 8'h00;
        done = 1'b0;
        repeat (6) cycle();
    endtask

    initial begin
        int got;
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        model_reset();
        #12;
        check("rst_gnt",       gnt,       0);
        check("rst_gnt_idx",   gnt_idx,   0);
        check("rst_gnt_valid", gnt_valid, 0);
        check("rst_timeout",   timeout,   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Rotation: all requesting, done after the third grant cycle.
        order.delete();
        req = 8'hFF;
        repeat (40) begin
            cycle();
            done = m_busy && (m_held == 3);
        end
        check("rot_count", order.size() >= 9, 1);
        for (int i = 0; i < 9; i++) begin
            got = (i < order.size()) ? order[i] : -1;
            check("rot_order", got, i % 8);
        end

        // Single requester held for three cycles, then pointer moves to 4.
        drain();
        req = 8'h08;
        cycle();
        check("single_gnt", gnt, 8'h08);
        check("single_idx1", gnt_idx, 3);
        cycle();
        check("single_idx2", gnt_idx, 3);
        cycle();
        check("single_idx3", gnt_idx, 3);
        done = 1'b1;
        cycle();
        check("single_release", gnt, 8'h00);
        done = 1'b0;
        req  = 8'h18;
        cycle();
        check("single_ptr", gnt_idx, 4);

        // Wrap: pointer at 6 with requests 0 and 5 grants 0 first, then 5.
        drain();
        req = 8'h20;
        cycle();
        done = 1'b1;
        cycle();
        done = 1'b0;
        req  = 8'h21;
        cycle();
        check("wrap_first", gnt, 8'h01);
        done = 1'b1;
        cycle();
        done = 1'b0;
        cycle();
        check("wrap_second", gnt_idx, 5);

        // Timeout: a lone holder is revoked after MAX_HOLD cycles.
        drain();
        req = 8'h10;
        cycle();
        check("to_gnt", gnt, 8'h10);
        repeat (3) begin
            cycle();
            check("to_hold", gnt, 8'h10);
        end
        cycle();
        check("to_revoke", gnt, 8'h00);
        check("to_pulse", timeout, 1);
        cycle();
        check("to_pulse_end", timeout, 0);
        check("to_regrant", gnt, 8'h10);
        req = 8'h18;
        repeat (4) cycle();
        cycle();
        check("to_other", gnt_idx, 3);

        // Random traffic.
        drain();
        repeat (400) begin
            if ($urandom_range(0, 3) == 0)
                req = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            done = ($urandom_range(0, 4) == 0);
            cycle();
        end

        // Done coincident with the timeout cycle is a normal release.
        drain();
        req = 8'h04;
        cycle();
        repeat (3) cycle();
        done = 1'b1;
        cycle();
        check("sim_release", gnt, 8'h00);
        check("sim_no_timeout", timeout, 0);
        done = 1'b0;
        req  = 8'h02;
        cycle();
        check("drop_gnt", gnt, 8'h02);
        req = 8'h00;
        cycle();
        check("drop_release", gnt, 8'h00);

        // Asynchronous reset in the middle of a grant.
        req = 8'h04;
        cycle();
        check("pre_rst_gnt", gnt, 8'h04);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_gnt",   gnt,       0);
        check("rst_async_valid", gnt_valid, 0);
        check("rst_async_idx",   gnt_idx,   0);
        model_reset();
        req = 8'h00;
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        check("rst_idle", gnt_valid, 0);
        req = 8'h05;
        cycle();
        check("rst_ptr", gnt_idx, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
